// File: rtl/aes_shift_rows_pipe.sv
// Pipelined AES/Rijndael ShiftRows stage with per-beat forward/inverse/bypass
// mode, valid/ready flow control and a configurable number of register stages.
module aes_shift_rows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [32*NB-1:0]                     in_data,
  input  logic                                 in_inv,
  input  logic                                 in_bypass,
  input  logic [TAG_W-1:0]                     in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [32*NB-1:0]                     out_data,
  output logic [TAG_W-1:0]                     out_tag,
  output logic [$clog2(PIPE_STAGES+1)-1:0]     occupancy
);

  localparam int DW    = 32 * NB;
  localparam int OCC_W = $clog2(PIPE_STAGES + 1);

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("aes_shift_rows_pipe: PIPE_STAGES must be in 1..4");
    end
  endgenerate

  // Rijndael uses a larger row-2/row-3 offset only for the 256-bit block.
  function automatic int shift_of(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [DW-1:0]          perm;
  logic [PIPE_STAGES-1:0] stage_valid;
  logic [PIPE_STAGES-1:0] advance;
  logic [DW-1:0]          stage_data [PIPE_STAGES];
  logic [TAG_W-1:0]       stage_tag  [PIPE_STAGES];

  always_comb begin
    int src;
    perm = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (in_bypass) begin
          src = c;
        end else if (in_inv) begin
          src = (c + NB - shift_of(r)) % NB;
        end else begin
          src = (c + shift_of(r)) % NB;
        end
        perm[DW-1-8*(r+4*c) -: 8] = in_data[DW-1-8*(r+4*src) -: 8];
      end
    end
  end

  // A stage may move forward when it is empty or everything after it moves.
  always_comb begin
    logic go;
    go = !stage_valid[PIPE_STAGES-1] || out_ready;
    advance[PIPE_STAGES-1] = go;
    for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
      go = !stage_valid[k] || go;
      advance[k] = go;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_data[k] <= '0;
        stage_tag[k]  <= '0;
      end
    end else begin
      if (advance[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) begin
          stage_data[0] <= perm;
          stage_tag[0]  <= in_tag;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (advance[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) begin
            stage_data[k] <= stage_data[k-1];
            stage_tag[k]  <= stage_tag[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      occupancy = occupancy + OCC_W'(stage_valid[k]);
    end
  end

  assign in_ready  = advance[0];
  assign out_valid = stage_valid[PIPE_STAGES-1];
  assign out_data  = stage_data[PIPE_STAGES-1];
  assign out_tag   = stage_tag[PIPE_STAGES-1];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Scoreboard bench for aes_shift_rows_pipe: an NB=4/2-stage instance for the
// flow-control, random and reset scenarios, and an NB=8/3-stage instance.
module tb_aes_shift_rows_pipe;

  typedef struct {
    logic [255:0] d;
    logic [3:0]   t;
  } beat_t;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, in_inv, in_bypass;
  logic [127:0] in_data;
  logic [3:0]   in_tag;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_tag;
  logic [1:0]   occupancy;

  logic         b_in_valid, b_in_ready, b_in_inv, b_in_bypass;
  logic [255:0] b_in_data;
  logic [3:0]   b_in_tag;
  logic         b_out_valid, b_out_ready;
  logic [255:0] b_out_data;
  logic [3:0]   b_out_tag;
  logic [1:0]   b_occupancy;

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];
  beat_t b_exp_q[$];
  bit    b_done   = 0;
  bit    rand_done;

  aes_shift_rows_pipe #(.NB(4), .PIPE_STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .in_bypass(in_bypass), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .occupancy(occupancy)
  );

  aes_shift_rows_pipe #(.NB(8), .PIPE_STAGES(3), .TAG_W(4)) dut_wide (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_inv(b_in_inv), .in_bypass(b_in_bypass), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .occupancy(b_occupancy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Reference for NB=4: rows rotated by scattering each input byte to its target column.
  function automatic logic [127:0] ref_shift4(input logic [127:0] d, input logic inv,
                                              input logic byp);
    logic [7:0]   st [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[127-8*(r+4*c) -: 8];
    res = d;
    if (!byp) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (inv) res[127-8*(r+4*((c+r)%4)) -: 8] = st[r][c];
          else     res[127-8*(r+4*((c+4-r)%4)) -: 8] = st[r][c];
    end
    return res;
  endfunction

  task automatic applyStimulus(input logic [127:0] d, input logic inv, input logic byp,
                               input logic [3:0] tag, input logic [127:0] expected);
    bit accepted = 0;
    int waited = 0;
    in_valid = 1; in_data = d; in_inv = inv; in_bypass = byp; in_tag = tag;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (accepted) exp_q.push_back('{d: {128'd0, expected}, t: tag});
    else checkOutput("accept_timeout", 256'd0, 256'd1);
    in_valid = 0;
  endtask

  task automatic applyStimulusWide(input logic [255:0] d, input logic inv, input logic byp,
                                   input logic [3:0] tag, input logic [255:0] expected);
    bit accepted = 0;
    int waited = 0;
    b_in_valid = 1; b_in_data = d; b_in_inv = inv; b_in_bypass = byp; b_in_tag = tag;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      accepted = b_in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (accepted) b_exp_q.push_back('{d: expected, t: tag});
    else checkOutput("wide_accept_timeout", 256'd0, 256'd1);
    b_in_valid = 0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(name, 256'(exp_q.size()), 256'd0);
  endtask

  // Monitor for the NB=4 instance: pops on every transfer, checks hold while stalled.
  bit           stalled = 0;
  logic [127:0] held_data;
  logic [3:0]   held_tag;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checkOutput("stall_valid", 256'(out_valid), 256'd1);
        checkOutput("stall_data", 256'(out_data), 256'(held_data));
        checkOutput("stall_tag", 256'(out_tag), 256'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat actual=%h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", 256'(out_data), e.d);
          checkOutput("beat_tag", 256'(out_tag), 256'(e.t));
        end
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_tag  = out_tag;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wide_unexpected_beat actual=%h required=none", b_out_data);
      end else begin
        e = b_exp_q.pop_front();
        checkOutput("wide_beat_data", b_out_data, e.d);
        checkOutput("wide_beat_tag", 256'(b_out_tag), 256'(e.t));
      end
    end
  end

  // NB=8 stream: bytes 00..1f forward, its inverse, then bypass.
  initial begin
    logic [255:0] seq, fwd;
    int n;
    seq = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    fwd = 256'h00050e13040912170800d161b0c111a1f10151e0314190207181d060b1c010a0f;
    fwd = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;
    b_in_valid = 0; b_in_data = '0; b_in_inv = 0; b_in_bypass = 0; b_in_tag = '0;
    b_out_ready = 1;
    @(negedge rst);
    @(posedge clk);
    #1;
    applyStimulusWide(seq, 1'b0, 1'b0, 4'h1, fwd);
    applyStimulusWide(fwd, 1'b1, 1'b0, 4'h2, seq);
    applyStimulusWide(seq, 1'b1, 1'b1, 4'h3, seq);
    n = 0;
    while (b_exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("wide_drain", 256'(b_exp_q.size()), 256'd0);
    b_done = 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] fips_in, fips_out, va, vb, vc, rd;
    logic         ri, rb;
    logic [3:0]   rt;
    fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
    fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    rst = 0; in_valid = 0; in_data = '0; in_inv = 0; in_bypass = 0; in_tag = '0;
    out_ready = 0;
    #2 rst = 1;
    #20;
    checkOutput("reset_out_valid", 256'(out_valid), 256'd0);
    checkOutput("reset_occupancy", 256'(occupancy), 256'd0);
    checkOutput("reset_out_data", 256'(out_data), 256'd0);
    checkOutput("reset_out_tag", 256'(out_tag), 256'd0);
    @(posedge clk);
    #3 rst = 0;
    @(negedge clk);
    checkOutput("reset_in_ready", 256'(in_ready), 256'd1);

    $display("[TB] directed NB=4 vectors");
    @(posedge clk);
    #1;
    out_ready = 1;
    applyStimulus(fips_in, 1'b0, 1'b0, 4'h3, fips_out);
    @(negedge clk);
    checkOutput("latency_early", 256'(out_valid), 256'd0);
    @(negedge clk);
    checkOutput("latency_due", 256'(out_valid), 256'd1);
    @(posedge clk);
    #1;
    applyStimulus(fips_out, 1'b1, 1'b0, 4'h5, fips_in);
    applyStimulus(fips_out, 1'b1, 1'b1, 4'h6, fips_out);
    waitDrain("drain_directed");

    $display("[TB] backpressure with full pipeline");
    va = 128'h00112233445566778899aabbccddeeff;
    vb = 128'h0123456789abcdef0f1e2d3c4b5a6978;
    vc = 128'hfedcba98765432100011223344556677;
    @(posedge clk);
    #1;
    out_ready = 0;
    fork
      begin
        applyStimulus(va, 1'b0, 1'b0, 4'h7, ref_shift4(va, 1'b0, 1'b0));
        applyStimulus(vb, 1'b1, 1'b0, 4'h8, ref_shift4(vb, 1'b1, 1'b0));
        applyStimulus(vc, 1'b0, 1'b1, 4'h9, vc);
      end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("full_occupancy", 256'(occupancy), 256'd2);
    checkOutput("full_in_ready", 256'(in_ready), 256'd0);
    checkOutput("full_held_tag", 256'(in_tag), 256'd9);
    @(posedge clk);
    #1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_gap_valid", 256'(out_valid), 256'd1);
    end
    wait fork;
    waitDrain("drain_stall");

    $display("[TB] random traffic");
    rand_done = 0;
    fork
      while (!rand_done) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
      end
      rd = {$urandom, $urandom, $urandom, $urandom};
      ri = 1'($urandom_range(0, 1));
      rb = ($urandom_range(0, 3) == 0);
      rt = 4'($urandom);
      applyStimulus(rd, ri, rb, rt, ref_shift4(rd, ri, rb));
    end
    rand_done = 1;
    @(posedge clk);
    #2;
    out_ready = 1;
    waitDrain("drain_random");

    $display("[TB] asynchronous reset mid-stream");
    wait (b_done);
    @(posedge clk);
    #1;
    out_ready = 0;
    applyStimulus(va, 1'b0, 1'b0, 4'h1, ref_shift4(va, 1'b0, 1'b0));
    applyStimulus(vb, 1'b0, 1'b0, 4'h2, ref_shift4(vb, 1'b0, 1'b0));
    #3 rst = 1;
    #1;
    checkOutput("async_out_valid", 256'(out_valid), 256'd0);
    checkOutput("async_occupancy", 256'(occupancy), 256'd0);
    checkOutput("async_out_data", 256'(out_data), 256'd0);
    checkOutput("async_out_tag", 256'(out_tag), 256'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #3 rst = 0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 256'(in_ready), 256'd1);
    @(posedge clk);
    #1;
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(fips_in, 1'b0, 1'b0, 4'ha, fips_out);
    waitDrain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
- Parametrised, pipelined successor to the combinational AES ShiftRows stage.
- Supports Rijndael block widths of Nb = 4, 6 or 8 columns.
- Per-transaction mode: forward ShiftRows, InvShiftRows or bypass.
- Valid/ready streaming interface with a configurable register depth and full-throughput backpressure; sits between SubBytes and MixColumns in the round datapath, and the inverse mode serves the decryptor.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; any other value fails elaboration.
- PIPE_STAGES, 2, register stages; legal range 1..4.
- TAG_W, 4, width of the sideband tag carried alongside each block.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  32*NB  state; byte b = row + 4*col occupies bits [32*NB-1-8b -: 8] (byte 0 in the MSBs, column-major).
- in_inv  input  1  1 = InvShiftRows, 0 = forward.
- in_bypass  input  1  1 = pass through unpermuted; overrides in_inv.
- in_tag  input  TAG_W  sideband, returned unchanged with the block.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts.
- out_data  output  32*NB  permuted state, same byte layout as in_data.
- out_tag  output  TAG_W  tag of the block on out_data.
- occupancy  output  $clog2(PIPE_STAGES+1)  number of valid stages.

Behaviour:
- Shift offsets per row r (s0, s1, s2, s3):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Permutation:
  - Forward: out[r][c] = in[r][(c + s_r) mod NB].
  - Inverse: out[r][c] = in[r][(c - s_r) mod NB], with the modulo non-negative.
  - Bypass: out = in.
- The permutation is combinational on the input side and registered into stage 1. Stages 2..PIPE_STAGES are plain data/tag/valid registers.
- Handshake and flow:
  - A beat transfers when valid and ready are both high on a rising edge.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready is high or it is empty.
  - in_ready = stage 1 empty or stage 1 advances. in_ready may depend combinationally on out_ready.
  - out_valid is the valid bit of the last stage.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N + PIPE_STAGES - 1. With out_ready held high this is PIPE_STAGES cycles of latency.
  - Throughput: 1 beat per cycle when unstalled.
  - Bubbles collapse: an empty stage fills even while downstream is stalled.
- AXI-style stability rules:
  - While out_valid is high and out_ready is low, out_data, out_tag and out_valid hold stable.
  - The source must hold in_* stable while in_valid is high and in_ready is low.
  - in_data, in_inv, in_bypass and in_tag are ignored when in_valid is low.
- Simultaneous accept and emit in the same cycle with all stages full: legal, occupancy unchanged, no beat lost or duplicated.
- Ordering: strictly FIFO; the mode is captured per beat, so mixed forward/inverse/bypass beats may be in flight together.
- occupancy: counts valid stages, updated every edge, never exceeds PIPE_STAGES.
- Reset (asynchronous, any time including mid-stream):
  - All stage valid bits clear, so out_valid = 0 and occupancy = 0.
  - out_data = 0 and out_tag = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - Blocks in flight are discarded.

Test Plan:
- NB=4, forward, in_data = d42711aee0bf98f1b8b45de51e415230, tag 3 -> out_data = d4bf5d30e0b452aeb84111f11e2798e5, out_tag 3, PIPE_STAGES cycles after acceptance.
- NB=4, in_inv=1, in_data = d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230. With in_bypass=1 and in_inv=1 the same input is returned unchanged.
- NB=8, forward, input bytes 00..1f (byte b = b) -> first output column 00 05 0e 13. The inverse of that output returns 00..1f.
- PIPE_STAGES=2, out_ready held 0, in_valid held 1 with beats A, B, C:
  - A and B are accepted, occupancy = 2, in_ready = 0, C is held.
  - out_ready raised -> A, B, C emerge in order on consecutive cycles with no gaps.
- Random valid/ready toggling over 1000 beats with mixed modes -> output stream matches a reference model beat for beat, and the out_* signals never change while stalled.
- rst pulsed with 2 beats in flight -> out_valid = 0, occupancy = 0 and out_data = 0 immediately (asynchronous). No stale beat appears after release; the next accepted beat emerges correctly.
